mips_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon-style memory bus used by mips_cpu_bus. The bus signals are address, read, write, writedata, byteenable, readdata and waitrequest. Master 0 is the CPU. Master 1 is a loader/DMA/debug port. The single slave is the RAM model, e.g. ram_tiny_CPU. The arbiter grants the slave to one master per transfer, uses round-robin on ties, and keeps the grant until the slave completes the transfer.

---
 rtl/mips_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master / one-slave arbiter for the Avalon-style
// memory bus. Master 0 is the CPU and master 1 is a loader/DMA/debug port.
// The slave is granted to one master per transfer. One arbitration cycle in
// IDLE precedes every grant, and ties go round-robin. The grant is held until
// the slave completes the transfer.
//
// Optional feature macro: MIPS_BUS_ARB_TIMEOUT_EN. When it is defined, a
// transfer whose slave stalls for TIMEOUT_CYCLES granted cycles is aborted.
// The abort pulses bus_error and returns 32'hDEADBEEF to the master.
//
// Handshake: a master requests by raising read and/or write. It must hold
// address, read, write, writedata and byteenable stable while its
// waitrequest is 1. The transfer completes in the cycle where the granted
// master sees waitrequest=0.
module mips_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,
    output logic [AW-1:0]     s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DW-1:0]     s_writedata,
    output logic [DW/8-1:0]   s_byteenable,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_waitrequest,
    output logic [1:0]        grant,
    output logic              bus_error,
    output logic [1:0]        dbg_state,
    output logic              dbg_rr_last
);

    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       rr_last, rr_last_nxt;
    logic [1:0] grant_nxt;
    logic       req0, req1;
    logic       abort;

    assign req0        = m0_read | m0_write;
    assign req1        = m1_read | m1_write;
    assign dbg_state   = state;
    assign dbg_rr_last = rr_last;

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] to_cnt;

    // The abort fires in the last allowed stalled cycle of a grant.
    assign abort     = (state != IDLE) && s_waitrequest && !reset &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus_error = abort;

    // Count consecutive stalled granted cycles; any state change restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if ((state != IDLE) && s_waitrequest) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign bus_error      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // State, round-robin pointer and grant register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            grant   <= 2'b00;
        end else begin
            state   <= state_nxt;
            rr_last <= rr_last_nxt;
            grant   <= grant_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, release on completion, abort or drop.
    always_comb begin
        state_nxt   = state;
        rr_last_nxt = rr_last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = rr_last ? GNT0 : GNT1;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest || abort) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest || abort) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant register input: one-hot decode of the next state.
    always_comb begin
        grant_nxt = 2'b00;
        case (state_nxt)
            GNT0:    grant_nxt = 2'b01;
            GNT1:    grant_nxt = 2'b10;
            default: grant_nxt = 2'b00;
        endcase
    end

    // Route the granted master to the slave. A waiting master is stalled.
    always_comb begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
        case (state)
            GNT0: begin
                s_read         = m0_read;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest & ~abort;
                if (abort) begin
                    m0_readdata = ABORT_DATA;
                end
            end
            GNT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest & ~abort;
                if (abort) begin
                    m1_readdata = ABORT_DATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Testbench for mips_bus_arbiter: a reset check, a table of per-cycle
// vectors, hand-written multi-cycle sequences, and a randomized phase that
// is scored against a transaction-level model.
module tb_mips_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;
    localparam int TW = 2 + AW + DW + BW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [1:0]    grant, dbg_state;
    logic          bus_error, dbg_rr_last;

    mips_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .bus_error(bus_error),
        .dbg_state(dbg_state), .dbg_rr_last(dbg_rr_last)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q0[$];
    logic [TW-1:0] exp_q1[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_consts();
        m0_address    = 32'hBFC00000;
        m0_writedata  = 32'hA5A5A5A5;
        m0_byteenable = 4'hF;
        m1_address    = 32'h00001000;
        m1_writedata  = 32'h12345678;
        m1_byteenable = 4'b0011;
        s_readdata    = 32'h24020005;
    endtask

    task automatic idle_all();
        m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0;
        s_waitrequest = 1'b0;
        drive_consts();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r0, w0, r1, w1, sw;
        logic [1:0] g;
        logic       sr, swr, wq0, wq1, src;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(input logic r0, w0, r1, w1, sw, input logic [1:0] g,
                                 input logic sr, swr, wq0, wq1, src);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.sw = sw;
        v.g = g; v.sr = sr; v.swr = swr; v.wq0 = wq0; v.wq1 = wq1; v.src = src;
        return v;
    endfunction

    // ---------------- random-phase variables ----------------
    int          owner, last, run, held, held_w, errs;
    logic        act[2];
    logic [1:0]  rw[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [BW-1:0] be[2];
    logic [TW-1:0] got;
    logic [1:0]  exp_g, exp_srw;
    logic        r0_now, r1_now, done, exp_w, tag;

    initial begin
        // ---------- reset values ----------
        do_reset();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_bus_error", bus_error, 1'b0);
        check("rst_s_rw", {s_write, s_read}, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        check("rst_rr_last", dbg_rr_last, 1'b1);
        check("rst_m_wait", {m1_waitrequest, m0_waitrequest}, 2'b00);
        next_cycle();

        // ---------- table: round-robin and stalled write from m1 ----------
        //              r0 w0 r1 w1 sw  grant  sr swr wq0 wq1 src
        tbl[0]  = mkv(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0);
        tbl[1]  = mkv(1, 0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0);
        tbl[2]  = mkv(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0);
        tbl[3]  = mkv(1, 0, 1, 0, 0, 2'b10, 1, 0, 1, 0, 1);
        tbl[4]  = mkv(1, 0, 0, 1, 0, 2'b00, 0, 0, 1, 1, 0);
        tbl[5]  = mkv(1, 0, 0, 1, 0, 2'b01, 1, 0, 0, 1, 0);
        tbl[6]  = mkv(1, 0, 0, 1, 0, 2'b00, 0, 0, 1, 1, 0);
        tbl[7]  = mkv(1, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1);
        tbl[8]  = mkv(1, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1);
        tbl[9]  = mkv(1, 0, 0, 1, 1, 2'b10, 0, 1, 1, 1, 1);
        tbl[10] = mkv(1, 0, 0, 1, 0, 2'b10, 0, 1, 1, 0, 1);
        tbl[11] = mkv(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        tbl[12] = mkv(1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0);
        tbl[13] = mkv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            m0_read = tbl[i].r0; m0_write = tbl[i].w0;
            m1_read = tbl[i].r1; m1_write = tbl[i].w1;
            s_waitrequest = tbl[i].sw;
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            check($sformatf("vec%0d_s_read", i), s_read, tbl[i].sr);
            check($sformatf("vec%0d_s_write", i), s_write, tbl[i].swr);
            check($sformatf("vec%0d_m0_wait", i), m0_waitrequest, tbl[i].wq0);
            check($sformatf("vec%0d_m1_wait", i), m1_waitrequest, tbl[i].wq1);
            check($sformatf("vec%0d_s_addr", i), s_address,
                  tbl[i].src ? 32'h00001000 : 32'hBFC00000);
            check($sformatf("vec%0d_s_wdata", i), s_writedata,
                  tbl[i].src ? 32'h12345678 : 32'hA5A5A5A5);
            check($sformatf("vec%0d_s_be", i), s_byteenable,
                  tbl[i].src ? 4'b0011 : 4'hF);
            next_cycle();
        end

        // ---------- single m0 read, m1 idle ----------
        m0_read = 1'b1;
        s_waitrequest = 1'b0;
        @(negedge clk);
        check("rd_arb_grant", grant, 2'b00);
        check("rd_arb_m0_wait", m0_waitrequest, 1'b1);
        check("rd_arb_m1_wait", m1_waitrequest, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rd_gnt_grant", grant, 2'b01);
        check("rd_gnt_m0_wait", m0_waitrequest, 1'b0);
        check("rd_gnt_m0_rdata", m0_readdata, 32'h24020005);
        check("rd_gnt_s_addr", s_address, 32'hBFC00000);
        check("rd_gnt_m1_wait", m1_waitrequest, 1'b0);
        next_cycle();

        // ---------- reset in the 2nd cycle of a GNT0 read ----------
        s_waitrequest = 1'b1;
        @(negedge clk);
        check("rm_arb_grant", grant, 2'b00);
        next_cycle();
        @(negedge clk);
        check("rm_c1_grant", grant, 2'b01);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rm_c2_grant", grant, 2'b01);
        check("rm_c2_s_read", s_read, 1'b1);
        next_cycle();
        reset = 1'b0;
        m1_read = 1'b1;
        @(negedge clk);
        check("rm_after_grant", grant, 2'b00);
        check("rm_after_s_read", s_read, 1'b0);
        check("rm_after_state", dbg_state, 2'd0);
        check("rm_after_rr_last", dbg_rr_last, 1'b1);
        next_cycle();
        @(negedge clk);
        check("rm_rearb_grant", grant, 2'b01);
        check("rm_rearb_m1_wait", m1_waitrequest, 1'b1);
        next_cycle();
        do_reset();

        // ---------- stuck slave ----------
        m0_read = 1'b1;
        m1_write = 1'b1;
        s_waitrequest = 1'b1;
        s_readdata = 32'h11111111;
        @(negedge clk);
        check("stall_arb_grant", grant, 2'b00);
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("to_c%0d_grant", k), grant, 2'b01);
            check($sformatf("to_c%0d_bus_error", k), bus_error, k == TO);
            check($sformatf("to_c%0d_m0_wait", k), m0_waitrequest, k != TO);
            if (k == TO) check("to_m0_rdata", m0_readdata, 32'hDEADBEEF);
        end
        next_cycle();
        m0_read = 1'b0;
        @(negedge clk);
        check("to_idle_grant", grant, 2'b00);
        check("to_idle_bus_error", bus_error, 1'b0);
        next_cycle();
        @(negedge clk);
        check("to_m1_grant", grant, 2'b10);
        check("to_m1_s_write", s_write, 1'b1);
        check("to_m1_s_addr", s_address, 32'h00001000);
`else
        held = 0; held_w = 0; errs = 0;
        for (int k = 1; k <= 110; k++) begin
            next_cycle();
            @(negedge clk);
            if (grant == 2'b01) held++;
            if (m0_waitrequest) held_w++;
            if (bus_error !== 1'b0) errs++;
        end
        check("stall_grant_held", held, 110);
        check("stall_m0_wait_held", held_w, 110);
        check("stall_no_bus_error", errs, 0);
        next_cycle();
        s_waitrequest = 1'b0;
        @(negedge clk);
        check("stall_release_m0_wait", m0_waitrequest, 1'b0);
        check("stall_release_grant", grant, 2'b01);
`endif
        next_cycle();
        do_reset();

        // ---------- randomized traffic vs transaction model ----------
        owner = -1; last = 1; run = 0;
        act[0] = 1'b0; act[1] = 1'b0;
        rw[0] = 2'b00; rw[1] = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m] = 1'b1;
                    rw[m]  = 2'($urandom_range(1, 3));
                    ad[m]  = AW'($urandom);
                    ad[m][AW-1] = (m == 1);
                    wd[m]  = DW'($urandom);
                    be[m]  = BW'($urandom);
                    if (m == 0) exp_q0.push_back({rw[m], ad[m], wd[m], be[m]});
                    else        exp_q1.push_back({rw[m], ad[m], wd[m], be[m]});
                end
            end
            m0_read = act[0] & rw[0][0]; m0_write = act[0] & rw[0][1];
            m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
            m1_read = act[1] & rw[1][0]; m1_write = act[1] & rw[1][1];
            m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
            if (run >= 3) s_waitrequest = 1'b0;
            else          s_waitrequest = ($urandom_range(0, 9) < 4);
            run = s_waitrequest ? run + 1 : 0;
            s_readdata = DW'($urandom);
            @(negedge clk);

            exp_g   = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
            exp_srw = (owner < 0) ? 2'b00 : rw[owner];
            check("rnd_grant", grant, exp_g);
            check("rnd_bus_error", bus_error, 1'b0);
            check("rnd_s_rw", {s_write, s_read}, exp_srw);

            if ((s_read | s_write) && !s_waitrequest) begin
                got = {s_write, s_read, s_address, s_writedata, s_byteenable};
                tag = s_address[AW-1];
                check("rnd_slave_owner", tag, (owner < 0) ? 2 : owner);
                if (tag == 1'b0) begin
                    check("rnd_q0_pending", exp_q0.size(), 1);
                    if (exp_q0.size() > 0) check("rnd_xfer0", got, exp_q0.pop_front());
                end else begin
                    check("rnd_q1_pending", exp_q1.size(), 1);
                    if (exp_q1.size() > 0) check("rnd_xfer1", got, exp_q1.pop_front());
                end
            end

            r0_now = act[0];
            r1_now = act[1];
            for (int m = 0; m < 2; m++) begin
                done  = act[m] && (owner == m) && !s_waitrequest;
                exp_w = act[m] && !done;
                check($sformatf("rnd_m%0d_wait", m),
                      (m == 0) ? m0_waitrequest : m1_waitrequest, exp_w);
                if (done) begin
                    if (rw[m][0])
                        check($sformatf("rnd_m%0d_rdata", m),
                              (m == 0) ? m0_readdata : m1_readdata, s_readdata);
                    act[m] = 1'b0;
                end
            end

            // A free bus spends one cycle arbitrating; a busy bus frees on completion.
            if (owner < 0) begin
                if (r0_now && r1_now) owner = 1 - last;
                else if (r0_now)      owner = 0;
                else if (r1_now)      owner = 1;
            end else if (!s_waitrequest) begin
                last  = owner;
                owner = -1;
            end
            next_cycle();
        end
        check("rnd_q0_left", exp_q0.size(), act[0] ? 1 : 0);
        check("rnd_q1_left", exp_q1.size(), act[1] ? 1 : 0);

        // ---------- report ----------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
